// File: rtl/preif_pc_gen.sv
// preif_pc_gen: pre-IF fetch PC generator.
//
// Produces one fetch-group request per cycle. The group is FETCH_NUM
// instructions (GB = FETCH_NUM*4 bytes) and always ends on a GB boundary, so a
// redirect into the middle of a group only enables the slots at or above the
// target's slot.
//
// Ports:
//   clk           - clock, all state on rising edge
//   rst_n         - asynchronous active-low reset
//   excp_flush_i  - exception/ertn redirect pulse (highest priority)
//   excp_pc_i     - exception redirect target
//   br_flush_i    - branch redirect pulse (honoured only in RUN)
//   br_pc_i       - branch redirect target
//   if_allowin_i  - IF stage accepts the group this cycle
//   pc_o          - current fetch PC
//   valid_o       - pc_o is a valid request
//   slot_mask_o   - bit i set = slot i of the group is a valid instruction
//   adef_o        - fetch address error (pc_o not word aligned)
module preif_pc_gen #(
  parameter int                    PC_WIDTH  = 32,
  parameter int                    FETCH_NUM = 2,
  parameter logic [PC_WIDTH-1:0]   RESET_PC  = 32'h1C00_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 excp_flush_i,
  input  logic [PC_WIDTH-1:0]  excp_pc_i,
  input  logic                 br_flush_i,
  input  logic [PC_WIDTH-1:0]  br_pc_i,
  input  logic                 if_allowin_i,
  output logic [PC_WIDTH-1:0]  pc_o,
  output logic                 valid_o,
  output logic [FETCH_NUM-1:0] slot_mask_o,
  output logic                 adef_o
);

  localparam int GB = FETCH_NUM * 4;
  localparam int OB = $clog2(GB);

  // IDLE: one dead cycle after reset. SHADOW: first cycle after an exception
  // redirect, during which a (stale) branch redirect must be ignored.
  // WAIT: a misaligned group was handed to IF; stall until an exception.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_SHADOW = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_seq;
  logic                fire;

  assign valid_o = (state_q == S_RUN) || (state_q == S_SHADOW);
  assign pc_o    = pc_q;
  assign adef_o  = valid_o && (pc_q[1:0] != 2'b00);
  assign fire    = valid_o && if_allowin_i;

  // Next group starts at the following GB boundary; wraps silently at the top.
  assign pc_seq = {pc_q[PC_WIDTH-1:OB], {OB{1'b0}}} + PC_WIDTH'(GB);

  generate
    if (FETCH_NUM == 1) begin : g_mask_one
      assign slot_mask_o = 1'b1;
    end else begin : g_mask_multi
      localparam int IW = OB - 2;
      logic [IW-1:0] slot_idx;
      assign slot_idx = pc_q[OB-1:2];
      always_comb begin
        slot_mask_o = '0;
        for (int i = 0; i < FETCH_NUM; i++) begin
          slot_mask_o[i] = (IW'(i) >= slot_idx);
        end
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (excp_flush_i) begin
      pc_d    = excp_pc_i;
      state_d = S_SHADOW;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_RUN;
        S_RUN, S_SHADOW: begin
          if ((state_q == S_RUN) && br_flush_i) begin
            // Unaccepted current group is simply replaced.
            pc_d = br_pc_i;
          end else if (fire && adef_o) begin
            // Faulting group was handed over; hold pc for the handler.
            state_d = S_WAIT;
          end else begin
            if (fire) pc_d = pc_seq;
            state_d = S_RUN;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: doc/preif_pc_gen.md
PREIF_PC_GEN -- requirements
Module: preif_pc_gen

Interface
REQ-001 Parameter PC_WIDTH, default 32, width of all PC buses.
REQ-002 Parameter FETCH_NUM, default 2, instructions per fetch group; legal values 1, 2, 4; GB = FETCH_NUM*4 bytes; OB = log2(GB).
REQ-003 Parameter RESET_PC, default 32'h1C00_0000, first fetch address; GB-aligned.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 excp_flush_i  in  1  exception/ertn redirect pulse from writeback.
REQ-007 excp_pc_i  in  PC_WIDTH  exception redirect target.
REQ-008 br_flush_i  in  1  branch redirect pulse from ID.
REQ-009 br_pc_i  in  PC_WIDTH  branch redirect target.
REQ-010 if_allowin_i  in  1  IF stage can accept a group this cycle.
REQ-011 pc_o  out  PC_WIDTH  current fetch PC.
REQ-012 valid_o  out  1  pc_o is a valid request.
REQ-013 slot_mask_o  out  FETCH_NUM  bit i set = slot i of group holds a valid instruction.
REQ-014 adef_o  out  1  fetch-address error: pc_o[1:0] != 0.

Function
REQ-015 fire = valid_o & if_allowin_i; group transfers to IF only on fire.
REQ-016 FSM states IDLE, RUN, SHADOW, WAIT; state register only, no other hidden storage besides pc.
REQ-017 IDLE: valid_o=0; unconditional transition to RUN next cycle.
REQ-018 RUN/SHADOW: valid_o=1; WAIT: valid_o=0.
REQ-019 Sequential next PC = (pc_o with low OB bits cleared) + GB, modulo 2^PC_WIDTH (wrap from top to 0, no flag).
REQ-020 slot_mask_o bit i = 1 iff i >= pc_o[OB-1:2]; FETCH_NUM=1 -> slot_mask_o = 1'b1 always.
REQ-021 adef_o = valid_o & (pc_o[1:0] != 0), combinational; slot_mask_o unaffected.
REQ-022 Priority per cycle: excp_flush_i > br_flush_i > sequential advance on fire > hold.
REQ-023 excp_flush_i in any state (incl. IDLE): pc <= excp_pc_i, state <= SHADOW next cycle, regardless of if_allowin_i.
REQ-024 br_flush_i in RUN without excp_flush_i: pc <= br_pc_i, state stays RUN, regardless of if_allowin_i; unaccepted current group is discarded.
REQ-025 br_flush_i ignored in IDLE, SHADOW and WAIT.
REQ-026 SHADOW lasts exactly one cycle: on fire advances sequentially; either way state <= RUN next cycle (unless excp_flush_i).
REQ-027 No fire and no redirect: pc and state hold; pc_o, slot_mask_o stable.
REQ-028 Fire while adef_o=1 (RUN or SHADOW, no redirect): pc holds, state <= WAIT; WAIT exits only on excp_flush_i.
REQ-029 Redirect target with pc[1:0] != 0 is loaded unchanged; adef handled per REQ-028.
REQ-030 Outputs purely from registered pc/state; no combinational path from inputs to outputs.

Reset
REQ-031 rst_n=0 asynchronously forces pc=RESET_PC, state=IDLE: valid_o=0, adef_o=0, pc_o=RESET_PC, slot_mask_o all ones.
REQ-032 Reset mid-operation discards any pending redirect and in-flight state; first valid_o=1 is pc_o=RESET_PC one cycle after rst_n release.
REQ-033 Redirect inputs sampled during reset are ignored.

Verification
REQ-034 FETCH_NUM=2, reset release, if_allowin_i=1 -> valid_o rises after 1 cycle; pc_o 1C000000, 1C000008, 1C000010; slot_mask_o=2'b11.
REQ-035 FETCH_NUM=2, br_flush_i with br_pc_i=1C000104 while if_allowin_i=0 -> next pc_o=1C000104, slot_mask_o=2'b10; after fire pc_o=1C000108, mask 2'b11.
REQ-036 excp_flush_i (excp_pc_i=1C008000) and br_flush_i same cycle, then br_flush_i next cycle -> pc_o=1C008000 and second branch ignored; third-cycle branch honored.
REQ-037 br_flush_i with br_pc_i=1C000102 -> adef_o=1; on fire valid_o=0 and pc held until excp_flush_i loads 1C008000, valid_o=1.
REQ-038 PC_WIDTH=32, FETCH_NUM=4, pc_o=FFFFFFF4, fire -> pc_o=00000000, mask 4'b1111; rst_n low mid-stream -> pc_o=RESET_PC, valid_o=0 immediately.
